// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: issue / operand-fetch stage in front of the register file.
// It holds one decoded instruction and tracks registers with a pending write
// in a busy scoreboard. It stalls on RAW/WAW hazards, reads sources through
// the two RF read ports, and registers the operands toward execute.
// Optional feature macro: OPFETCH_WB_BYPASS_EN. When it is defined, data
// written back in the same cycle is forwarded into the operands and can also
// release a WAW stall. When it is undefined, a dependent instruction waits
// for the cycle after the writeback.
//
// state | meaning
// EMPTY | hold register free
// HELD  | hold register contains one instruction awaiting issue
module operand_fetch_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int REG_COUNT     = 16,
    parameter int ADDR_WIDTH    = $clog2(REG_COUNT),
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     async_rst,
    input  logic                     clk_en,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic                     in_use_a,
    input  logic                     in_use_b,
    input  logic [ADDR_WIDTH-1:0]    in_src_a,
    input  logic [ADDR_WIDTH-1:0]    in_src_b,
    input  logic                     in_wr_dst,
    input  logic [ADDR_WIDTH-1:0]    in_dst,
    output logic                     rf_rd_en_a,
    output logic                     rf_rd_en_b,
    output logic [ADDR_WIDTH-1:0]    rf_rd_addr_a,
    output logic [ADDR_WIDTH-1:0]    rf_rd_addr_b,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data_a,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data_b,
    input  logic                     wb_valid,
    input  logic [ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [DATA_WIDTH-1:0]    out_op_a,
    output logic [DATA_WIDTH-1:0]    out_op_b,
    output logic                     out_wr_dst,
    output logic [ADDR_WIDTH-1:0]    out_dst
);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t                   state;
    logic [PAYLOAD_WIDTH-1:0] h_payload;
    logic                     h_use_a;
    logic                     h_use_b;
    logic [ADDR_WIDTH-1:0]    h_src_a;
    logic [ADDR_WIDTH-1:0]    h_src_b;
    logic                     h_wr_dst;
    logic [ADDR_WIDTH-1:0]    h_dst;
    logic [REG_COUNT-1:0]     busy;
    logic [REG_COUNT-1:0]     busy_nxt;

    logic                     byp_a;
    logic                     byp_b;
    logic                     dst_wb;
    logic                     a_rdy;
    logic                     b_rdy;
    logic                     dst_rdy;
    logic                     slot_free;
    logic                     issue;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    op_a_nxt;
    logic [DATA_WIDTH-1:0]    op_b_nxt;

`ifdef OPFETCH_WB_BYPASS_EN
    assign byp_a  = wb_valid && (wb_addr == h_src_a);
    assign byp_b  = wb_valid && (wb_addr == h_src_b);
    assign dst_wb = wb_valid && (wb_addr == h_dst);
`else
    // Without forwarding, the writeback data only reaches execute through the RF.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp_a  = 1'b0;
    assign byp_b  = 1'b0;
    assign dst_wb = 1'b0;
`endif

    assign rf_rd_en_a   = (state == HELD) && h_use_a;
    assign rf_rd_en_b   = (state == HELD) && h_use_b;
    assign rf_rd_addr_a = h_src_a;
    assign rf_rd_addr_b = h_src_b;

    // Hazard checks, issue decision and operand selection for the held instruction.
    always_comb begin
        a_rdy     = !h_use_a  || !busy[h_src_a] || byp_a;
        b_rdy     = !h_use_b  || !busy[h_src_b] || byp_b;
        dst_rdy   = !h_wr_dst || !busy[h_dst]   || dst_wb;
        slot_free = !out_valid || out_ready;
        issue     = (state == HELD) && clk_en && !flush && a_rdy && b_rdy
                    && dst_rdy && slot_free;
        in_ready  = clk_en && !flush && !async_rst && ((state == EMPTY) || issue);
        accept    = in_valid && in_ready;
        op_a_nxt  = '0;
        op_b_nxt  = '0;
        if (h_use_a) op_a_nxt = byp_a ? wb_data : rf_rd_data_a;
        if (h_use_b) op_b_nxt = byp_b ? wb_data : rf_rd_data_b;
    end

    // Scoreboard update: the writeback clear is applied first so that a same-index issue set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_addr] = 1'b0;
        if (issue && h_wr_dst) busy_nxt[h_dst] = 1'b1;
    end

    // FSM and hold register.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state     <= EMPTY;
            h_payload <= '0;
            h_use_a   <= 1'b0;
            h_use_b   <= 1'b0;
            h_src_a   <= '0;
            h_src_b   <= '0;
            h_wr_dst  <= 1'b0;
            h_dst     <= '0;
        end else if (clk_en) begin
            if (flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state     <= HELD;
                h_payload <= in_payload;
                h_use_a   <= in_use_a;
                h_use_b   <= in_use_b;
                h_src_a   <= in_src_a;
                h_src_b   <= in_src_b;
                h_wr_dst  <= in_wr_dst;
                h_dst     <= in_dst;
            end else if (issue) begin
                state <= EMPTY;
            end
        end
    end

    // Output register toward execute; it holds while execute back-pressures.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_op_a    <= '0;
            out_op_b    <= '0;
            out_wr_dst  <= 1'b0;
            out_dst     <= '0;
        end else if (clk_en) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (issue) begin
                out_valid   <= 1'b1;
                out_payload <= h_payload;
                out_op_a    <= op_a_nxt;
                out_op_b    <= op_b_nxt;
                out_wr_dst  <= h_wr_dst;
                out_dst     <= h_dst;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Scoreboard register: writeback clears still land while the stage is disabled.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) busy <= '0;
        else           busy <= busy_nxt;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a small register-file model.
// Expectations follow OPFETCH_WB_BYPASS_EN when it is defined.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic        clk_en, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_payload;
    logic        in_use_a, in_use_b;
    logic [3:0]  in_src_a, in_src_b;
    logic        in_wr_dst;
    logic [3:0]  in_dst;
    logic        rf_rd_en_a, rf_rd_en_b;
    logic [3:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [63:0] rf_rd_data_a, rf_rd_data_b;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_payload;
    logic [63:0] out_op_a, out_op_b;
    logic        out_wr_dst;
    logic [3:0]  out_dst;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] rf [16];

    operand_fetch_stage dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_use_a(in_use_a), .in_use_b(in_use_b),
        .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_wr_dst(in_wr_dst), .in_dst(in_dst),
        .rf_rd_en_a(rf_rd_en_a), .rf_rd_en_b(rf_rd_en_b),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_wr_dst(out_wr_dst), .out_dst(out_dst)
    );

    always #5 clk = ~clk;

    // Register file model: written by the same writeback port, read combinationally.
    always @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 64'(i);
            rf[3] <= 64'h11;
            rf[4] <= 64'h22;
        end else if (wb_valid) begin
            rf[wb_addr] <= wb_data;
        end
    end
    assign rf_rd_data_a = rf[rf_rd_addr_a];
    assign rf_rd_data_b = rf[rf_rd_addr_b];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pl, input logic ua, input logic [3:0] sa,
                         input logic ub, input logic [3:0] sb, input logic wd, input logic [3:0] d);
        in_valid = v; in_payload = pl; in_use_a = ua; in_src_a = sa;
        in_use_b = ub; in_src_b = sb; in_wr_dst = wd; in_dst = d;
    endtask

    initial begin
        async_rst = 1'b1;
        clk_en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_payload", 64'(out_payload), 64'd0);
        chk("rst_busy", 64'(dut.busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick(); tick();
        async_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic fetch, then RAW on r5 resolved by a later writeback.
        out_ready = 1'b1;
        drive(1, 32'hA1, 1, 4'd3, 1, 4'd4, 1, 4'd5);
        tick();
        chk("lat_out_valid", 64'(out_valid), 64'd0);
        chk("rd_en_a", 64'(rf_rd_en_a), 64'd1);
        chk("rd_addr_a", 64'(rf_rd_addr_a), 64'd3);
        chk("rd_en_b", 64'(rf_rd_en_b), 64'd1);
        chk("rd_addr_b", 64'(rf_rd_addr_b), 64'd4);
        drive(1, 32'hB2, 1, 4'd5, 0, 4'd0, 0, 4'd0);
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("i1_valid", 64'(out_valid), 64'd1);
        chk("i1_op_a", out_op_a, 64'h11);
        chk("i1_op_b", out_op_b, 64'h22);
        chk("i1_dst", 64'(out_dst), 64'd5);
        chk("i1_wr_dst", 64'(out_wr_dst), 64'd1);
        chk("i1_payload", 64'(out_payload), 64'hA1);
        chk("i1_busy5", 64'(dut.busy[5]), 64'd1);
        tick();
        chk("raw_stall_valid", 64'(out_valid), 64'd0);
        chk("raw_stall_addr", 64'(rf_rd_addr_a), 64'd5);
        chk("raw_stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("raw_stall_valid2", 64'(out_valid), 64'd0);
        wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 64'hAB;
        tick();
        wb_valid = 1'b0;
`ifdef OPFETCH_WB_BYPASS_EN
        chk("raw_byp_valid", 64'(out_valid), 64'd1);
`else
        chk("raw_wait_valid", 64'(out_valid), 64'd0);
        tick();
        chk("raw_rf_valid", 64'(out_valid), 64'd1);
`endif
        chk("raw_op_a", out_op_a, 64'hAB);
        chk("raw_op_b_unused", out_op_b, 64'd0);
        chk("raw_payload", 64'(out_payload), 64'hB2);
        chk("raw_busy5", 64'(dut.busy[5]), 64'd0);
        tick();
        chk("raw_drain", 64'(out_valid), 64'd0);

        // Back-pressure with one instruction in the output and one held.
        out_ready = 1'b0;
        drive(1, 32'hC1, 1, 4'd3, 1, 4'd4, 0, 4'd9);
        tick();
        drive(1, 32'hC2, 1, 4'd4, 0, 4'd0, 0, 4'd0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_payload", 64'(out_payload), 64'hC1);
            chk("bp_op_a", out_op_a, 64'h11);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_c2_valid", 64'(out_valid), 64'd1);
        chk("bp_c2_payload", 64'(out_payload), 64'hC2);
        chk("bp_c2_op_a", out_op_a, 64'h22);
        chk("bp_c2_op_b", out_op_b, 64'd0);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // WAW on r7.
        drive(1, 32'hD1, 0, 4'd0, 0, 4'd0, 1, 4'd7);
        tick();
        drive(1, 32'hD2, 0, 4'd0, 0, 4'd0, 1, 4'd7);
        tick();
        in_valid = 1'b0;
        chk("waw_d1_payload", 64'(out_payload), 64'hD1);
        chk("waw_busy7", 64'(dut.busy[7]), 64'd1);
        chk("waw_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("waw_stall_valid", 64'(out_valid), 64'd0);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 64'h77;
        tick();
        wb_valid = 1'b0;
`ifdef OPFETCH_WB_BYPASS_EN
        chk("waw_set_wins_busy7", 64'(dut.busy[7]), 64'd1);
`else
        chk("waw_clear_busy7", 64'(dut.busy[7]), 64'd0);
        chk("waw_wait_valid", 64'(out_valid), 64'd0);
        tick();
        chk("waw_reset_busy7", 64'(dut.busy[7]), 64'd1);
`endif
        chk("waw_d2_valid", 64'(out_valid), 64'd1);
        chk("waw_d2_payload", 64'(out_payload), 64'hD2);
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 64'h78;
        tick();
        wb_valid = 1'b0;
        chk("waw_busy_clean", 64'(dut.busy), 64'd0);

        // Flush while HELD and out_valid.
        drive(1, 32'hE1, 0, 4'd0, 0, 4'd0, 1, 4'd2);
        tick();
        drive(1, 32'hE2, 0, 4'd0, 0, 4'd0, 1, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_busy", 64'(dut.busy), 64'h0004);
        chk("fl_in_ready_after", 64'(in_ready), 64'd1);
        tick();
        chk("fl_no_issue", 64'(out_valid), 64'd0);
        clk_en = 1'b0;
        #1;
        chk("clk_en_low_in_ready", 64'(in_ready), 64'd0);
        clk_en = 1'b1;

        // Reset mid-stall with busy[5] set.
        out_ready = 1'b0;
        drive(1, 32'hF1, 0, 4'd0, 0, 4'd0, 1, 4'd5);
        tick();
        drive(1, 32'hF2, 1, 4'd5, 0, 4'd0, 0, 4'd0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mr_busy5", 64'(dut.busy[5]), 64'd1);
        chk("mr_valid", 64'(out_valid), 64'd1);
        #2 async_rst = 1'b1;
        #1;
        chk("mr_rst_valid", 64'(out_valid), 64'd0);
        chk("mr_rst_busy", 64'(dut.busy), 64'd0);
        chk("mr_rst_payload", 64'(out_payload), 64'd0);
        chk("mr_rst_rd_en_a", 64'(rf_rd_en_a), 64'd0);
        #1 async_rst = 1'b0;
        #1;
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("mr_idle", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
